// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: byte-stream instruction issue and write-back sequencer in front of an 8-bit ALU
module alu_issue_ctrl #(
    parameter int DATA_W      = 8,
    parameter int IMM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [7:0]        alu_word,
    output logic              alu_strobe,
    input  logic [DATA_W-1:0] alu_out,
    output logic [1:0]        cmp_flags,
    output logic              done,
    output logic              err,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int TW = $clog2(IMM_TIMEOUT + 1);
    localparam logic [3:0] OP_NOP = 4'b0000, OP_MVI = 4'b0001, OP_MOV = 4'b0010, OP_ILL = 4'b0011;

    typedef enum logic [1:0] {IDLE, FETCH_IMM, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [7:0]        word_q, word_d, imm_q, imm_d, alu_word_q, alu_word_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    logic [1:0]        cmp_q, cmp_d;
    logic              strobe_q, strobe_d, err_q, err_d;

    function automatic logic is_reg_alu(input logic [3:0] op);
        return op inside {4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1010};
    endfunction

    function automatic logic is_imm_alu(input logic [3:0] op);
        return op inside {4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1001, 4'b1011};
    endfunction

    logic [3:0] in_op, wb_op;
    assign in_op = in_byte[7:4];
    assign wb_op = word_q[7:4];

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        imm_d      = imm_q;
        timer_d    = timer_q;
        regs_d     = regs_q;
        cmp_d      = cmp_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_word_d = alu_word_q;
        strobe_d   = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                word_d  = in_byte;
                timer_d = '0;
                if (in_op == OP_ILL) begin
                    err_d = 1'b1;
                end else if (is_imm_alu(in_op) || in_op == OP_MVI) begin
                    state_d = FETCH_IMM;
                end else if (is_reg_alu(in_op)) begin
                    state_d    = EXEC;
                    strobe_d   = 1'b1;
                    alu_in1_d  = regs_q[in_byte[3:2]];
                    alu_in2_d  = regs_q[in_byte[1:0]];
                    alu_word_d = in_byte;
                end else begin
                    state_d = WB;
                end
            end
            FETCH_IMM: if (in_valid) begin
                imm_d = in_byte;
                if (wb_op == OP_MVI) begin
                    state_d = WB;
                end else begin
                    state_d    = EXEC;
                    strobe_d   = 1'b1;
                    alu_in1_d  = regs_q[word_q[3:2]];
                    alu_in2_d  = in_byte;
                    alu_word_d = word_q;
                end
            end else if (timer_q == TW'(IMM_TIMEOUT - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            EXEC: state_d = WB;
            WB: begin
                state_d = IDLE;
                // compares update only the flags; everything else targets rd
                if (wb_op == 4'b0111 || wb_op == 4'b1111)
                    cmp_d = alu_out[1:0];
                else if (is_reg_alu(wb_op) || is_imm_alu(wb_op))
                    regs_d[word_q[3:2]] = alu_out;
                else if (wb_op == OP_MVI)
                    regs_d[word_q[3:2]] = imm_q;
                else if (wb_op == OP_MOV)
                    regs_d[word_q[3:2]] = regs_q[word_q[1:0]];
                else if (wb_op != OP_NOP)
                    cmp_d = cmp_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            imm_q      <= '0;
            timer_q    <= '0;
            regs_q     <= '{default: '0};
            cmp_q      <= '0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            alu_word_q <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            imm_q      <= imm_d;
            timer_q    <= timer_d;
            regs_q     <= regs_d;
            cmp_q      <= cmp_d;
            alu_in1_q  <= alu_in1_d;
            alu_in2_q  <= alu_in2_d;
            alu_word_q <= alu_word_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

    // gated with rst_n so nothing is accepted while reset is held
    assign in_ready   = rst_n && (state_q == IDLE || state_q == FETCH_IMM);
    assign done       = state_q == WB;
    assign err        = err_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_word   = alu_word_q;
    assign alu_strobe = strobe_q;
    assign cmp_flags  = cmp_q;
    assign dbg_data   = regs_q[dbg_sel];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector bench for alu_issue_ctrl with a behavioural ALU model
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_in1, alu_in2, alu_word;
    logic       alu_strobe;
    logic [7:0] alu_out = 8'h00;
    logic [1:0] cmp_flags;
    logic       done, err;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    int         total = 0;
    int         passed = 0;

    alu_issue_ctrl #(.DATA_W(8), .IMM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_word(alu_word), .alu_strobe(alu_strobe),
        .alu_out(alu_out), .cmp_flags(cmp_flags), .done(done), .err(err),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU model: add, sub, and, compare, or, xor
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] w);
        case (w[7:4])
            4'h4, 4'hC: return a + b;
            4'h5, 4'hD: return a - b;
            4'h6, 4'hE: return a & b;
            4'h7, 4'hF: return (a < b) ? 8'h01 : (a > b) ? 8'h02 : 8'h00;
            4'h8, 4'h9: return a | b;
            4'hA, 4'hB: return a ^ b;
            default:    return 8'h00;
        endcase
    endfunction

    always @(posedge alu_strobe) begin
        #1;
        alu_out = alu_f(alu_in1, alu_in2, alu_word);
    end

    typedef struct {
        logic [7:0] op;
        bit         has_imm;
        logic [7:0] imm;
        int         lat;
        logic [1:0] sel;
        logic [7:0] exp_d;
        logic [1:0] exp_f;
    } vec_t;

    vec_t va [2];
    vec_t vb [8];
    logic [7:0] s [5];
    int acc [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_dbg(input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        chk($sformatf("dbg_R%0d", sel), dbg_data, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        in_byte  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        send(v.op);
        if (v.has_imm) send(v.imm);
        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency_%0h", v.op), n, v.lat);
        @(negedge clk);
        chk_dbg(v.sel, v.exp_d);
        chk($sformatf("flags_%0h", v.op), cmp_flags, v.exp_f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int n;
        va[0] = '{8'h14, 1, 8'h05, 1, 2'd1, 8'h05, 2'b00};
        va[1] = '{8'h18, 1, 8'h03, 1, 2'd2, 8'h03, 2'b00};
        vb[0] = '{8'hC4, 1, 8'hFA, 2, 2'd1, 8'h02, 2'b00};
        vb[1] = '{8'hF4, 1, 8'h02, 2, 2'd1, 8'h02, 2'b00};
        vb[2] = '{8'h79, 0, 8'h00, 2, 2'd2, 8'h03, 2'b10};
        vb[3] = '{8'hF4, 1, 8'h09, 2, 2'd1, 8'h02, 2'b01};
        vb[4] = '{8'h00, 0, 8'h00, 1, 2'd1, 8'h02, 2'b01};
        vb[5] = '{8'h2E, 0, 8'h00, 1, 2'd3, 8'h03, 2'b01};
        vb[6] = '{8'h10, 1, 8'h0C, 1, 2'd0, 8'h0C, 2'b01};
        vb[7] = '{8'h4F, 0, 8'h00, 2, 2'd3, 8'h06, 2'b01};
        s = '{8'h81, 8'h60, 8'h41, 8'hA8, 8'h5C};

        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; dbg_sel = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_strobe", alu_strobe, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_flags", cmp_flags, 0);
        chk("rst_alu_word", alu_word, 0);
        for (int i = 0; i < 4; i++) chk_dbg(2'(i), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);

        foreach (va[i]) run_vec(va[i]);

        send(8'h46);
        chk("sum_strobe_hi", alu_strobe, 1);
        chk("sum_in1", alu_in1, 8'h05);
        chk("sum_in2", alu_in2, 8'h03);
        chk("sum_word", alu_word, 8'h46);
        chk("exec_in_ready", in_ready, 0);
        @(negedge clk);
        chk("sum_strobe_lo", alu_strobe, 0);
        chk("sum_done", done, 1);
        chk("wb_in_ready", in_ready, 0);
        @(negedge clk);
        chk("sum_done_lo", done, 0);
        chk_dbg(2'd1, 8'h08);

        foreach (vb[i]) run_vec(vb[i]);

        send(8'h30);
        chk("ill_err", err, 1);
        chk("ill_done", done, 0);
        chk("ill_idle", in_ready, 1);
        @(negedge clk);
        chk("ill_err_lo", err, 0);

        send(8'hD4);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_in_ready", in_ready, 1);
        chk("timeout_done", done, 0);
        chk("timeout_flags", cmp_flags, 2'b01);
        chk_dbg(2'd1, 8'h02);
        @(negedge clk);
        chk("timeout_err_lo", err, 0);

        idx = 0;
        in_valid = 1'b1;
        in_byte = s[0];
        for (int c = 0; c < 60 && idx < 5; c++) begin
            if (in_ready) begin
                acc[idx] = c;
                idx++;
            end
            @(negedge clk);
            if (idx < 5) in_byte = s[idx];
        end
        in_valid = 1'b0;
        chk("stream_count", idx, 5);
        for (int i = 1; i < 5; i++) chk($sformatf("stream_gap%0d", i), acc[i] - acc[i-1], 3);
        repeat (2) @(negedge clk);
        chk_dbg(2'd0, 8'h10);
        chk_dbg(2'd2, 8'h13);
        chk_dbg(2'd3, 8'hF6);

        send(8'hA8);
        chk("xrr_strobe", alu_strobe, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", alu_strobe, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_flags", cmp_flags, 0);
        for (int i = 0; i < 4; i++) chk_dbg(2'(i), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_done", done, 0);
        chk("arst_ready_after", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
